// File: rtl/sequence_checker_pkg.sv
// Shared types and constants for the Genius sequence checker.
package sequence_checker_pkg;

  localparam int DEFAULT_MAX_LEN = 32;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    CHK_IDLE       = 3'd0,
    CHK_FETCH      = 3'd1,
    CHK_LATCH      = 3'd2,
    CHK_WAIT_PRESS = 3'd3,
    CHK_PASS       = 3'd4,
    CHK_FAIL       = 3'd5
  } chk_state_t;

endpackage

// File: rtl/sequence_checker_if.sv
// Control, press and sequence-RAM signals between the game controller side and the checker.
interface sequence_checker_if #(
  parameter int ADDR_W = 5
);
  logic              start_check;
  logic [ADDR_W:0]   round_len;
  logic              abort;
  logic              valid_press;
  logic [1:0]        decoded_color;
  logic              seq_rd_en;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        seq_rd_data;
  logic              player_wr;
  logic              busy;
  logic [ADDR_W:0]   progress;
  logic              round_ok;
  logic              round_fail;
  logic              fail_timeout;

  modport master (
    output start_check, round_len, abort, valid_press, decoded_color, seq_rd_data,
    input  seq_rd_en, seq_addr, player_wr, busy, progress, round_ok, round_fail, fail_timeout
  );

  modport slave (
    input  start_check, round_len, abort, valid_press, decoded_color, seq_rd_data,
    output seq_rd_en, seq_addr, player_wr, busy, progress, round_ok, round_fail, fail_timeout
  );
endinterface

// File: rtl/sequence_checker_press_timer.sv
// Per-press timeout counter: cleared before each wait, counts while enabled.
module sequence_checker_press_timer #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  // expired marks the cycle whose increment would bring the count to TIMEOUT_CYCLES-1,
  // which makes the LATCH cycle the first of TIMEOUT_CYCLES cycles in the press window
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] count_r;

  // wait-cycle counter, saturating at the expiry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (enable && (count_r != LAST_CNT)) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // expiry flag
  always_comb begin
    if (enable && (count_r == LAST_CNT)) begin
      expired = 1'b1;
    end else begin
      expired = 1'b0;
    end
  end
endmodule

// File: rtl/sequence_checker.sv
// Compares player presses against the stored colour sequence and reports round pass/fail.
module sequence_checker
  import sequence_checker_pkg::*;
#(
  parameter int MAX_LEN        = DEFAULT_MAX_LEN,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input logic               clk,
  input logic               rst_n,
  sequence_checker_if.slave bus
);
  localparam int ADDR_W = $clog2(MAX_LEN);
  localparam int LEN_W  = ADDR_W + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  chk_state_t        state_r;
  logic [LEN_W-1:0]  len_r, idx_r, len_clamped_s, idx_inc_s;
  color_t            expected_r, pending_color_r, press_color_s;
  logic              pending_r, press_s, overrun_s, last_s;
  logic              timer_clear_s, timer_en_s, expired_s;
  logic              seq_rd_en_r, player_wr_r, busy_r;
  logic              round_ok_r, round_fail_r, fail_timeout_r;
  logic [ADDR_W-1:0] seq_addr_r;

  sequence_checker_press_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (expired_s)
  );

  // press source selection and round bookkeeping
  always_comb begin
    if (bus.round_len > MAX_LEN_L) begin
      len_clamped_s = MAX_LEN_L;
    end else begin
      len_clamped_s = bus.round_len;
    end
    if (pending_r) begin
      press_color_s = pending_color_r;
    end else begin
      press_color_s = color_t'(bus.decoded_color);
    end
    press_s       = bus.valid_press | pending_r;
    overrun_s     = bus.valid_press & pending_r;
    idx_inc_s     = idx_r + LEN_W'(1);
    last_s        = (idx_r == (len_r - LEN_W'(1)));
    timer_clear_s = (state_r == CHK_LATCH);
    timer_en_s    = (state_r == CHK_WAIT_PRESS);
  end

  // checker FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= CHK_IDLE;
      len_r           <= {LEN_W{1'b0}};
      idx_r           <= {LEN_W{1'b0}};
      expected_r      <= GREEN;
      pending_r       <= 1'b0;
      pending_color_r <= GREEN;
      seq_rd_en_r     <= 1'b0;
      seq_addr_r      <= {ADDR_W{1'b0}};
      player_wr_r     <= 1'b0;
      busy_r          <= 1'b0;
      round_ok_r      <= 1'b0;
      round_fail_r    <= 1'b0;
      fail_timeout_r  <= 1'b0;
    end else begin
      seq_rd_en_r    <= 1'b0;
      round_ok_r     <= 1'b0;
      round_fail_r   <= 1'b0;
      fail_timeout_r <= 1'b0;
      if (bus.abort) begin
        state_r     <= CHK_IDLE;
        pending_r   <= 1'b0;
        player_wr_r <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          CHK_IDLE: begin
            if (bus.start_check) begin
              len_r  <= len_clamped_s;
              idx_r  <= {LEN_W{1'b0}};
              busy_r <= 1'b1;
              if (len_clamped_s == {LEN_W{1'b0}}) begin
                state_r    <= CHK_PASS;
                round_ok_r <= 1'b1;
              end else begin
                state_r     <= CHK_FETCH;
                seq_rd_en_r <= 1'b1;
                seq_addr_r  <= {ADDR_W{1'b0}};
                player_wr_r <= 1'b1;
              end
            end
          end
          CHK_FETCH, CHK_LATCH: begin
            if (state_r == CHK_LATCH) begin
              expected_r <= color_t'(bus.seq_rd_data);
            end
            if (overrun_s) begin
              state_r      <= CHK_FAIL;
              round_fail_r <= 1'b1;
              player_wr_r  <= 1'b0;
              pending_r    <= 1'b0;
            end else begin
              // presses during the fetch turnaround wait in the one-entry buffer
              if (bus.valid_press) begin
                pending_r       <= 1'b1;
                pending_color_r <= color_t'(bus.decoded_color);
              end
              if (state_r == CHK_FETCH) begin
                state_r <= CHK_LATCH;
              end else begin
                state_r <= CHK_WAIT_PRESS;
              end
            end
          end
          CHK_WAIT_PRESS: begin
            if (overrun_s) begin
              state_r      <= CHK_FAIL;
              round_fail_r <= 1'b1;
              player_wr_r  <= 1'b0;
              pending_r    <= 1'b0;
            end else if (press_s) begin
              pending_r <= 1'b0;
              if (press_color_s == expected_r) begin
                idx_r <= idx_inc_s;
                if (last_s) begin
                  state_r     <= CHK_PASS;
                  round_ok_r  <= 1'b1;
                  player_wr_r <= 1'b0;
                end else begin
                  state_r     <= CHK_FETCH;
                  seq_rd_en_r <= 1'b1;
                  seq_addr_r  <= idx_inc_s[ADDR_W-1:0];
                end
              end else begin
                state_r      <= CHK_FAIL;
                round_fail_r <= 1'b1;
                player_wr_r  <= 1'b0;
              end
            end else if (expired_s) begin
              state_r        <= CHK_FAIL;
              round_fail_r   <= 1'b1;
              fail_timeout_r <= 1'b1;
              player_wr_r    <= 1'b0;
            end
          end
          CHK_PASS, CHK_FAIL: begin
            state_r <= CHK_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r     <= CHK_IDLE;
            pending_r   <= 1'b0;
            player_wr_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.seq_rd_en    = seq_rd_en_r;
  assign bus.seq_addr     = seq_addr_r;
  assign bus.player_wr    = player_wr_r;
  assign bus.busy         = busy_r;
  assign bus.progress     = idx_r;
  assign bus.round_ok     = round_ok_r;
  assign bus.round_fail   = round_fail_r;
  assign bus.fail_timeout = fail_timeout_r;
endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench for sequence_checker: round results are queued at stimulus time and popped on pulses.
module tb_sequence_checker;
  localparam int MAX_LEN = 8;
  localparam int TMO     = 20;
  localparam int ADDR_W  = 3;

  typedef struct {
    bit ok;
    bit tmo;
    int prog;
    int at;
  } result_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc    = 0;
  int         errors = 0;
  int         checks = 0;
  logic [1:0] ram [MAX_LEN];
  result_t    sb_q [$];
  result_t    mon_e;

  sequence_checker_if #(.ADDR_W(ADDR_W)) bus ();

  sequence_checker #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sequence RAM model, one-cycle synchronous read
  always @(posedge clk) if (bus.seq_rd_en) bus.seq_rd_data <= ram[bus.seq_addr];

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // result monitor on the falling edge
  always @(negedge clk) begin
    if (rst_n && (bus.round_ok || bus.round_fail)) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_result", {bus.round_ok, bus.round_fail}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("round_ok", bus.round_ok, mon_e.ok);
        check_eq("round_fail", bus.round_fail, !mon_e.ok);
        check_eq("fail_timeout", bus.fail_timeout, mon_e.tmo);
        check_eq("progress", bus.progress, mon_e.prog);
        check_eq("result_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit ok, input bit tmo, input int prog, input int at);
    result_t r;
    r.ok = ok; r.tmo = tmo; r.prog = prog; r.at = at;
    sb_q.push_back(r);
  endtask

  task automatic start_round(input int len);
    bus.start_check = 1'b1;
    bus.round_len   = 4'(len);
    tick();
    bus.start_check = 1'b0;
  endtask

  task automatic press(input int c);
    bus.valid_press   = 1'b1;
    bus.decoded_color = 2'(c);
    tick();
    bus.valid_press   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check_eq("drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.start_check = 1'b0; bus.round_len = 4'd0; bus.abort = 1'b0;
    bus.valid_press = 1'b0; bus.decoded_color = 2'd0;
    for (int i = 0; i < MAX_LEN; i++) ram[i] = 2'(i % 4);
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_seq_rd_en", bus.seq_rd_en, 0);
    check_eq("rst_seq_addr", bus.seq_addr, 0);
    check_eq("rst_player_wr", bus.player_wr, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_progress", bus.progress, 0);
    check_eq("rst_round_ok", bus.round_ok, 0);
    check_eq("rst_round_fail", bus.round_fail, 0);
    check_eq("rst_fail_timeout", bus.fail_timeout, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();

    // full correct round
    start_round(4);
    check_eq("fetch_rd_en", bus.seq_rd_en, 1);
    check_eq("fetch_addr", bus.seq_addr, 0);
    check_eq("fetch_player_wr", bus.player_wr, 1);
    check_eq("fetch_busy", bus.busy, 1);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(1'b1, 1'b0, 4, cyc + 1);
      press(i);
      if (i == 0) begin
        check_eq("progress_first", bus.progress, 1);
        check_eq("addr_second", bus.seq_addr, 1);
      end
      if (i < 3) begin tick(); tick(); end
    end
    wait_drain(5);
    check_eq("progress_hold", bus.progress, 4);
    check_eq("idle_busy", bus.busy, 0);

    // wrong colour on second press
    start_round(4); tick(); tick();
    press(0); tick(); tick();
    push(1'b0, 1'b0, 1, cyc + 1);
    press(2);
    wait_drain(5);

    // timeout: fail lands 20 cycles after LATCH of the second entry
    start_round(2); tick(); tick();
    push(1'b0, 1'b1, 1, cyc + 22);
    press(0);
    wait_drain(40);

    // press on the expiry cycle wins
    start_round(2); tick(); tick();
    press(0);
    repeat (20) tick();
    push(1'b1, 1'b0, 2, cyc + 1);
    press(1);
    wait_drain(5);

    // presses during FETCH and LATCH go through the pending buffer
    start_round(2);
    press(0);
    repeat (3) tick();
    push(1'b1, 1'b0, 2, cyc + 2);
    press(1);
    wait_drain(5);

    // two presses in the turnaround overrun the buffer
    start_round(4);
    press(0);
    push(1'b0, 1'b0, 0, cyc + 1);
    press(1);
    wait_drain(5);

    // abort in WAIT_PRESS
    start_round(4); tick(); tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("abort_player_wr", bus.player_wr, 0);
    check_eq("abort_busy", bus.busy, 0);
    repeat (3) tick();

    // zero-length round
    push(1'b1, 1'b0, 0, cyc + 1);
    start_round(0);
    wait_drain(5);

    // over-long round_len clamps to MAX_LEN
    start_round(12); tick(); tick();
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i == MAX_LEN - 1) push(1'b1, 1'b0, MAX_LEN, cyc + 1);
      press(i % 4);
      if (i < MAX_LEN - 1) begin tick(); tick(); end
    end
    wait_drain(5);

    // start_check while busy is ignored
    start_round(2); tick();
    bus.start_check = 1'b1; bus.round_len = 4'd1;
    tick();
    bus.start_check = 1'b0;
    press(0);
    check_eq("busy_start_busy", bus.busy, 1);
    check_eq("busy_start_progress", bus.progress, 1);
    tick(); tick();
    push(1'b1, 1'b0, 2, cyc + 1);
    press(1);
    wait_drain(5);

    // asynchronous reset mid-round
    start_round(4); tick(); tick();
    press(0);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rd_en", bus.seq_rd_en, 0);
    check_eq("mid_rst_addr", bus.seq_addr, 0);
    check_eq("mid_rst_player_wr", bus.player_wr, 0);
    check_eq("mid_rst_busy", bus.busy, 0);
    check_eq("mid_rst_progress", bus.progress, 0);
    #2 rst_n = 1'b1;
    tick();
    push(1'b1, 1'b0, 0, cyc + 1);
    start_round(0);
    wait_drain(5);

    check_eq("queue_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
